// File: rtl/qpu_ifu_irstage.sv
// Instruction fetch + IR stage feeding the EXU decoder: one outstanding fetch,
// static backward-taken branch prediction, and EXU-driven redirect/flush.
module qpu_ifu_irstage #(
    parameter int                 PC_SIZE  = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ifu_req_valid,
    input  logic               ifu_req_ready,
    output logic [PC_SIZE-1:0] ifu_req_addr,
    input  logic               ifu_rsp_valid,
    input  logic [31:0]        ifu_rsp_instr,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [31:0]        ir_instr,
    output logic [PC_SIZE-1:0] ir_pc,
    output logic               ir_prdt_taken,
    input  logic               flush_req,
    input  logic [PC_SIZE-1:0] flush_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state;
    logic [PC_SIZE-1:0] fetch_pc;

    function automatic logic predict_taken(input logic [31:0] instr);
        return (instr[4:0] == 5'b11000) && instr[9];
    endfunction

    // Branch offset is a signed 14-bit word offset; the size cast sign-extends it.
    function automatic logic [PC_SIZE-1:0] next_fetch_pc(input logic [PC_SIZE-1:0] pc,
                                                         input logic [31:0]        instr);
        logic signed [13:0] b_imm;
        logic signed [15:0] b_off;
        b_imm = {instr[9:5], instr[23:15]};
        b_off = {b_imm, 2'b00};
        if (predict_taken(instr)) begin
            return pc + PC_SIZE'(b_off);
        end
        return pc + PC_SIZE'(4);
    endfunction

    // Issue only when the IR will be free by the time the response lands.
    assign ifu_req_valid = ~rst & (state == S_REQ) & ~flush_req & (~ir_valid | ir_ready);
    assign ifu_req_addr  = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_REQ;
            fetch_pc      <= RESET_PC;
            ir_valid      <= 1'b0;
            ir_instr      <= '0;
            ir_pc         <= '0;
            ir_prdt_taken <= 1'b0;
        end else if (flush_req) begin
            fetch_pc <= flush_pc;
            ir_valid <= 1'b0;
            case (state)
                S_WAIT, S_DROP: state <= ifu_rsp_valid ? S_REQ : S_DROP;
                default:        state <= S_REQ;
            endcase
        end else begin
            if (ir_valid && ir_ready) begin
                ir_valid <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (ifu_req_valid && ifu_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ifu_rsp_valid) begin
                        ir_instr      <= ifu_rsp_instr;
                        ir_pc         <= fetch_pc;
                        ir_prdt_taken <= predict_taken(ifu_rsp_instr);
                        ir_valid      <= 1'b1;
                        fetch_pc      <= next_fetch_pc(fetch_pc, ifu_rsp_instr);
                        state         <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (ifu_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule
